// File: rtl/switch_arbiter.sv
// Round-robin wormhole arbiter for one switch output port. An input port keeps the
// output from its first granted flit until its tail flit is accepted downstream.
module switch_arbiter #(
    parameter int PORTS     = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PORTS-1:0]     req,
    input  logic [PORTS-1:0]     tail,
    input  logic                 out_ack,
    output logic [PORTS-1:0]     grants,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_count
);

    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [PORTS-1:0]     grants_nxt;
    logic [PTR_W-1:0]     ptr, ptr_nxt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic [PTR_W-1:0]     owner;
    logic [PTR_W-1:0]     owner_after;
    logic                 xfer;
    logic                 tail_xfer;

    // First requester at or after start, wrapping; the port just before start is reached last.
    function automatic logic [PORTS-1:0] rr_pick(input logic [PORTS-1:0] r,
                                                 input logic [PTR_W-1:0] start);
        logic [PORTS-1:0] pick;
        logic             found;
        int               idx;
        logic [PTR_W-1:0] idx_w;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            idx = int'(start) + k;
            if (idx >= PORTS) idx = idx - PORTS;
            idx_w = idx[PTR_W-1:0];
            if (!found && r[idx_w]) begin
                pick[idx_w] = 1'b1;
                found       = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        owner = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grants[i]) owner = PTR_W'(i);
        end
    end

    assign owner_after = (owner == PTR_W'(PORTS - 1)) ? '0 : owner + PTR_W'(1);
    assign xfer        = (state == LOCKED) && |(grants & req) && out_ack;
    assign tail_xfer   = xfer && |(grants & tail);

    always_comb begin
        state_nxt  = state;
        grants_nxt = grants;
        ptr_nxt    = ptr;
        cnt_nxt    = pkt_count;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt  = LOCKED;
                    grants_nxt = rr_pick(req, ptr);
                end
            end
            LOCKED: begin
                // Hand over on the tail flit without an idle bubble; the old owner ranks last.
                if (tail_xfer) begin
                    ptr_nxt    = owner_after;
                    cnt_nxt    = pkt_count + CNT_WIDTH'(1);
                    grants_nxt = rr_pick(req, owner_after);
                    state_nxt  = (|req) ? LOCKED : IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                grants_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grants    <= '0;
            ptr       <= '0;
            pkt_count <= '0;
        end else begin
            state     <= state_nxt;
            grants    <= grants_nxt;
            ptr       <= ptr_nxt;
            pkt_count <= cnt_nxt;
        end
    end

    assign busy = (state == LOCKED);

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed-vector bench for switch_arbiter with hand-computed grant/count expectations.
module tb_switch_arbiter;

    localparam int PORTS = 5;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [PORTS-1:0] req;
    logic [PORTS-1:0] tail;
    logic             out_ack;
    logic [PORTS-1:0] grants;
    logic             busy;
    logic [CW-1:0]    pkt_count;

    int total = 0;
    int bad   = 0;

    switch_arbiter #(.PORTS(PORTS), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tail      (tail),
        .out_ack   (out_ack),
        .grants    (grants),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [PORTS-1:0] g,
                                input logic b, input logic [CW-1:0] c);
        check_val({tag, "_grants"}, 32'(grants), 32'(g));
        check_val({tag, "_busy"}, 32'(busy), 32'(b));
        check_val({tag, "_count"}, 32'(pkt_count), 32'(c));
    endtask

    logic [PORTS-1:0] rd_req [4];
    logic [PORTS-1:0] onehot;

    initial begin
        rst = 1'b1; req = '0; tail = '0; out_ack = 1'b0;
        step();
        step();
        expect_state("reset", 5'b00000, 1'b0, 3'd0);

        // First arbitration after reset starts at ptr 0
        rst = 1'b0; req = 5'b10110;
        step();
        expect_state("first_grant", 5'b00010, 1'b1, 3'd0);

        // Three-flit packet from port 1; other ports' tail bits must be ignored
        out_ack = 1'b1; tail = 5'b10100;
        step();
        expect_state("head", 5'b00010, 1'b1, 3'd0);
        step();
        expect_state("body", 5'b00010, 1'b1, 3'd0);
        tail = 5'b00010;
        step();
        expect_state("tail_handover", 5'b00100, 1'b1, 3'd1);

        // Port 2 stalls; req[2] drops for two cycles
        out_ack = 1'b0; tail = 5'b11011;
        rd_req[0] = 5'b10110; rd_req[1] = 5'b10010; rd_req[2] = 5'b10010; rd_req[3] = 5'b10110;
        for (int i = 0; i < 4; i++) begin
            req = rd_req[i];
            step();
            expect_state($sformatf("stall%0d", i), 5'b00100, 1'b1, 3'd1);
        end
        // Ack while owner not requesting is not a transfer
        req = 5'b10010; tail = 5'b11111; out_ack = 1'b1;
        step();
        expect_state("ack_no_req", 5'b00100, 1'b1, 3'd1);

        // Single-flit tail from 2; search starts at 3, finds 4
        req = 5'b10110; tail = 5'b00100;
        step();
        expect_state("single_tail", 5'b10000, 1'b1, 3'd2);

        // Reset, then all ports send single-flit packets back to back
        rst = 1'b1;
        step();
        expect_state("reset2", 5'b00000, 1'b0, 3'd0);
        rst = 1'b0; req = 5'b11111; tail = 5'b11111; out_ack = 1'b1;
        step();
        expect_state("rr_0", 5'b00001, 1'b1, 3'd0);
        for (int k = 1; k <= 5; k++) begin
            onehot = '0;
            onehot[k % 5] = 1'b1;
            step();
            expect_state($sformatf("rr_%0d", k), onehot, 1'b1, 3'(k));
        end

        // Owner 0 keeps lock while only port 3 requests
        req = 5'b01000; out_ack = 1'b0;
        step();
        expect_state("hold_owner0", 5'b00001, 1'b1, 3'd5);
        req = 5'b01001; tail = 5'b00001; out_ack = 1'b1;
        step();
        expect_state("to_port3", 5'b01000, 1'b1, 3'd6);
        // Sole requester 3 is re-granted after its own tail
        req = 5'b01000; tail = 5'b01000;
        step();
        expect_state("regrant3", 5'b01000, 1'b1, 3'd7);

        // Reset mid-packet with count 7; other inputs active
        rst = 1'b1; req = 5'b11111; tail = 5'b11111;
        step();
        expect_state("rst_locked", 5'b00000, 1'b0, 3'd0);
        step();
        expect_state("rst_held", 5'b00000, 1'b0, 3'd0);
        rst = 1'b0; req = 5'b10000; tail = 5'b00000;
        step();
        expect_state("post_rst", 5'b10000, 1'b1, 3'd0);

        // Counter wraps through 7 to 0
        req = 5'b11111; tail = 5'b11111; out_ack = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            onehot = '0;
            onehot[(k - 1) % 5] = 1'b1;
            step();
            expect_state($sformatf("wrap_%0d", k), onehot, 1'b1, 3'(k % 8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_arbiter.md
SWITCH_ARBITER -- requirements
Module: switch_arbiter

Interface
REQ-001 Parameter: PORTS, default 5, number of input ports competing for one output port (index 0 local, 1 west, 2 north, 3 east, 4 south).
REQ-002 Parameter: CNT_WIDTH, default 16, width of the forwarded-packet counter.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  PORTS  bit i = input buffer i holds a flit routed to this output.
REQ-006 Port: tail  input  PORTS  bit i = flit currently at head of buffer i is a tail (or single-flit) flit; valid only while req[i]=1.
REQ-007 Port: out_ack  input  1  downstream accepted the flit currently presented on this output.
REQ-008 Port: grants  output  PORTS  registered one-hot (or all-zero) grant vector driving the output multiplexer select.
REQ-009 Port: busy  output  1  high while a packet holds the output (state LOCKED).
REQ-010 Port: pkt_count  output  CNT_WIDTH  number of completed packets (tail flits transferred) since reset.

Function
REQ-011 States: IDLE (no owner, grants=0, busy=0) and LOCKED (exactly one grants bit set, busy=1).
REQ-012 Transfer event: xfer = LOCKED & req[g] & out_ack, where g = index of the set grants bit.
REQ-013 Round-robin pointer ptr (0..PORTS-1): winner = first i with req[i]=1 searching ptr, ptr+1, ..., wrapping modulo PORTS.
REQ-014 IDLE, req=0: stay IDLE, grants=0.
REQ-015 IDLE, req!=0: next cycle LOCKED, grants=onehot(winner); grant visible 1 cycle after req (registered).
REQ-016 LOCKED, no xfer: hold grants unchanged, including when req[g] drops (wormhole lock; no re-arbitration mid-packet).
REQ-017 LOCKED, xfer with tail[g]=0 (head/body flit): hold grants, state unchanged.
REQ-018 LOCKED, xfer with tail[g]=1: packet ends; ptr <= (g+1) mod PORTS; pkt_count increments by 1.
REQ-019 On tail xfer, the next owner is chosen in the same cycle from the current req vector, searching from (g+1) mod PORTS; if found, stay LOCKED with the new one-hot grant next cycle (no bubble), else go IDLE with grants=0.
REQ-020 On tail xfer, req[g] is still eligible but has lowest priority (reached last in the search).
REQ-021 Single-flit packet (tail=1 on the first transferred flit) releases exactly as in REQ-018/019.
REQ-022 ptr changes only on tail xfer; it does not change on IDLE grants.
REQ-023 pkt_count wraps from 2^CNT_WIDTH-1 to 0.
REQ-024 tail[i] and req[i] for non-granted ports never affect grants while LOCKED.
REQ-025 grants is never multi-hot; there is no combinational path from req, tail, or out_ack to grants.

Reset
REQ-026 rst=1 at a clock edge: state IDLE, grants=0, busy=0, ptr=0, pkt_count=0 next cycle, regardless of the other inputs.
REQ-027 Reset mid-packet drops the lock immediately; first arbitration after rst deasserts uses ptr=0.
REQ-028 While rst=1, no grant is issued and pkt_count does not increment.

Verification
REQ-029 Post-reset, req=5'b10110 -> next cycle grants=5'b00010 (ptr=0 gives index 1), busy=1.
REQ-030 Owner 1 sends head, body, tail with out_ack=1 each cycle; req=5'b10110 held -> grants stays 00010 for 3 xfers, then 00100 next cycle with no IDLE cycle, pkt_count=1.
REQ-031 Owner 2 mid-packet with out_ack=0 for 4 cycles and req[2] dropped for 2 of them -> grants holds 00100 throughout, pkt_count unchanged.
REQ-032 All 5 requesting single-flit packets continuously with out_ack=1, starting ptr=0 -> grant order 0,1,2,3,4,0 on consecutive cycles; pkt_count +1 per cycle.
REQ-033 Sole requester 3 sends single-flit tail xfer, req[3] still 1 -> grants stays 01000 (re-granted), ptr=4; if req=0 instead -> IDLE, grants=0.
REQ-034 rst asserted while LOCKED with pkt_count=7 -> next cycle grants=0, busy=0, pkt_count=0; req=5'b10000 after release -> grants=10000 one cycle later.
